// File: rtl/shift_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_pkg: shared shift op codes, width defaults and FSM encoding  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package shift_pkg;
   localparam int DATA_WIDTH  = 32;
   localparam int SHAMT_WIDTH = 5;

   localparam logic [1:0] SHIFT_SLL = 2'b00;
   localparam logic [1:0] SHIFT_SRL = 2'b10;
   localparam logic [1:0] SHIFT_SRA = 2'b11;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RESP = 1'b1;
endpackage
`default_nettype wire

// File: rtl/shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shifter: combinational 32-bit barrel shifter (SLL/SRL/SRA)         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module shifter #(
   parameter int DATA_WIDTH  = shift_pkg::DATA_WIDTH,
   parameter int SHAMT_WIDTH = shift_pkg::SHAMT_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]  A,
   input  logic [SHAMT_WIDTH-1:0] B,
   input  logic [1:0]             Shiftop,
   output logic [DATA_WIDTH-1:0]  Result
);
   import shift_pkg::*;

   // The reserved op 01 yields zero rather than any shift.
   always_comb begin
      Result = '0;
      case (Shiftop)
         SHIFT_SLL: Result = A << B;
         SHIFT_SRL: Result = A >> B;
         SHIFT_SRA: Result = $unsigned($signed(A) >>> B);
         default:   Result = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/shifter_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shifter_arbiter: round-robin sharing of one barrel shifter between |
// | two valid/ready requesters, with a registered response.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module shifter_arbiter #(
   parameter int DATA_WIDTH  = shift_pkg::DATA_WIDTH,
   parameter int SHAMT_WIDTH = shift_pkg::SHAMT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [DATA_WIDTH-1:0]  req0_A,
   input  logic [SHAMT_WIDTH-1:0] req0_B,
   input  logic [1:0]             req0_op,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [DATA_WIDTH-1:0]  req1_A,
   input  logic [SHAMT_WIDTH-1:0] req1_B,
   input  logic [1:0]             req1_op,
   output logic                   resp0_valid,
   input  logic                   resp0_ready,
   output logic [DATA_WIDTH-1:0]  resp0_result,
   output logic                   resp1_valid,
   input  logic                   resp1_ready,
   output logic [DATA_WIDTH-1:0]  resp1_result
);
   import shift_pkg::*;

   logic [0:0]             r_state;
   logic                   r_owner;
   logic                   r_lastGrant;
   logic [DATA_WIDTH-1:0]  r_resultQ;

   logic                   w_idle;
   logic                   w_grant0;
   logic                   w_grant1;
   logic                   w_accept;
   logic                   w_ownerReady;
   logic [DATA_WIDTH-1:0]  w_shiftA;
   logic [SHAMT_WIDTH-1:0] w_shiftB;
   logic [1:0]             w_shiftOp;
   logic [DATA_WIDTH-1:0]  w_shiftResult;

   assign w_idle = (r_state == IDLE);

   // Under contention the port that did not win last time is favoured.
   assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_lastGrant);
   assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_lastGrant);
   assign w_accept = w_grant0 || w_grant1;

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   assign w_shiftA  = w_grant1 ? req1_A  : req0_A;
   assign w_shiftB  = w_grant1 ? req1_B  : req0_B;
   assign w_shiftOp = w_grant1 ? req1_op : req0_op;

   shifter #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH)
   ) u_shifter (
      .A       (w_shiftA),
      .B       (w_shiftB),
      .Shiftop (w_shiftOp),
      .Result  (w_shiftResult)
   );

   assign w_ownerReady = r_owner ? resp1_ready : resp0_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_lastGrant <= 1'b1;
         r_resultQ   <= '0;
      end else if (r_state == IDLE) begin
         if (w_accept) begin
            r_resultQ   <= w_shiftResult;
            r_owner     <= w_grant1;
            r_lastGrant <= w_grant1;
            r_state     <= RESP;
         end
      end else if (w_ownerReady) begin
         r_state <= IDLE;
      end
   end

   assign resp0_valid  = (r_state == RESP) && !r_owner;
   assign resp1_valid  = (r_state == RESP) &&  r_owner;
   assign resp0_result = r_resultQ;
   assign resp1_result = r_resultQ;
endmodule
`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shifter_arbiter: directed self-checking bench for the arbiter   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_shifter_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_A = '0, req1_A = '0;
   logic [4:0]  req0_B = '0, req1_B = '0;
   logic [1:0]  req0_op = '0, req1_op = '0;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic [31:0] resp0_result, resp1_result;

   int nChecks = 0;
   int nErrors = 0;

   typedef struct {
      logic        port;
      logic [31:0] a;
      logic [4:0]  b;
      logic [1:0]  op;
      logic [31:0] expResult;
   } vec_t;

   vec_t vecs [8];

   shifter_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_A       (req0_A),
      .req0_B       (req0_B),
      .req0_op      (req0_op),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_A       (req1_A),
      .req1_B       (req1_B),
      .req1_op      (req1_op),
      .resp0_valid  (resp0_valid),
      .resp0_ready  (resp0_ready),
      .resp0_result (resp0_result),
      .resp1_valid  (resp1_valid),
      .resp1_ready  (resp1_ready),
      .resp1_result (resp1_result)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic runVec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      if (v.port) begin
         req1_valid = 1'b1; req1_A = v.a; req1_B = v.b; req1_op = v.op;
      end else begin
         req0_valid = 1'b1; req0_A = v.a; req0_B = v.b; req0_op = v.op;
      end
      #1;
      chk({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, ~v.port});
      chk({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, v.port});
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk({tag, "_respValid0"}, {31'd0, resp0_valid}, {31'd0, ~v.port});
      chk({tag, "_respValid1"}, {31'd0, resp1_valid}, {31'd0, v.port});
      chk({tag, "_result"}, v.port ? resp1_result : resp0_result, v.expResult);
      chk({tag, "_readyInResp"}, {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
      #1;
      chk({tag, "_respDone"}, {30'd0, resp0_valid, resp1_valid}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0001, 5'd4,  2'b00, 32'h0000_0010};
      vecs[1] = '{1'b1, 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF};
      vecs[2] = '{1'b1, 32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001};
      vecs[3] = '{1'b1, 32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF, 5'd3,  2'b01, 32'h0000_0000};
      vecs[5] = '{1'b0, 32'h7FFF_FFF0, 5'd4,  2'b11, 32'h07FF_FFFF};
      vecs[6] = '{1'b0, 32'h8000_0001, 5'd1,  2'b00, 32'h0000_0002};
      vecs[7] = '{1'b1, 32'hF000_0000, 5'd4,  2'b11, 32'hFF00_0000};

      // Reset state while rst is held
      #1;
      chk("rst_respValid", {30'd0, resp0_valid, resp1_valid}, 32'd0);
      chk("rst_ready",     {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("rst_result",    resp0_result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) runVec(vecs[i], i);

      // Contention from reset with both valids held: grants alternate 0,1,0,1
      doReset();
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      req0_A = 32'h1; req0_B = 5'd1; req0_op = 2'b00;
      req1_A = 32'h8; req1_B = 5'd1; req1_op = 2'b10;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic expPort;
         expPort = (i % 2) != 0;
         #1;
         chk($sformatf("rr%0d_ready", i), {30'd0, req0_ready, req1_ready},
             expPort ? 32'd1 : 32'd2);
         @(negedge clk);
         #1;
         chk($sformatf("rr%0d_resp", i), {30'd0, resp0_valid, resp1_valid},
             expPort ? 32'd1 : 32'd2);
         chk($sformatf("rr%0d_result", i), expPort ? resp1_result : resp0_result,
             expPort ? 32'h4 : 32'h2);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Backpressure on port 0 while port 1 waits; resp1_ready must be ignored
      doReset();
      resp0_ready = 1'b0; resp1_ready = 1'b1;
      req0_A = 32'h3;   req0_B = 5'd2; req0_op = 2'b00;
      req1_A = 32'h100; req1_B = 5'd8; req1_op = 2'b10;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d_resp", i), {30'd0, resp0_valid, resp1_valid}, 32'd2);
         chk($sformatf("bp%0d_result", i), resp0_result, 32'hC);
         chk($sformatf("bp%0d_ready", i), {30'd0, req0_ready, req1_ready}, 32'd0);
         @(negedge clk);
      end
      resp0_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_idleResp", {30'd0, resp0_valid, resp1_valid}, 32'd0);
      chk("bp_ready1",   {30'd0, req0_ready, req1_ready}, 32'd1);
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      chk("bp_resp1",   {30'd0, resp0_valid, resp1_valid}, 32'd1);
      chk("bp_result1", resp1_result, 32'h1);
      @(negedge clk);

      // Asynchronous reset during a stalled response
      doReset();
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      req1_A = 32'h5; req1_B = 5'd1; req1_op = 2'b00;
      req1_valid = 1'b1;
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      chk("ar_respBefore", {30'd0, resp0_valid, resp1_valid}, 32'd1);
      chk("ar_resultBefore", resp1_result, 32'hA);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_respDrop", {30'd0, resp0_valid, resp1_valid}, 32'd0);
      chk("ar_resultClr", resp1_result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("ar_noResp", {30'd0, resp0_valid, resp1_valid}, 32'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("ar_firstGrant", {30'd0, req0_ready, req1_ready}, 32'd2);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end
endmodule
`default_nettype wire
